// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter: register-file geometry and the
// requester-index width used by the round-robin pointer.
package wb_pkg;

  localparam int unsigned DW       = 16;
  localparam int unsigned AW       = 3;
  localparam int unsigned NREG     = 1 << AW;
  localparam logic [AW-1:0] RO_REG = AW'(7);

  // Pointer/index width sized for the largest supported requester count.
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = $clog2(MAX_NREQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index after ptr, wrapping mod N.
// Produces a one-hot grant and its encoded index.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    idx       = '0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    // Offsets 1..N visit every requester once, ptr itself last.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter for the 8 x 16-bit register file: round-robin grant over
// the requesters, registered write port, and per-register pending-write bits.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               stall,
  input  logic               claim_valid,
  input  logic [AW-1:0]      claim_reg,
  output logic               rf_write_en,
  output logic [AW-1:0]      rf_wreg,
  output logic [DW-1:0]      rf_writedata,
  output logic [NREG-1:0]    busy
);

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             accept;
  logic [AW-1:0]    sel_reg;
  logic [DW-1:0]    sel_data;

  logic             wen_q;
  logic [AW-1:0]    wreg_q;
  logic [DW-1:0]    wdata_q;
  logic [NREG-1:0]  busy_q, busy_d;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = stall ? '0 : grant;
  assign accept    = |req_ready;
  assign sel_reg   = req_reg[grant_idx*AW +: AW];
  assign sel_data  = req_data[grant_idx*DW +: DW];

  // Clear on capture first so a same-edge claim of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[wreg_q] = 1'b0;
    end
    if (claim_valid && (claim_reg != RO_REG)) begin
      busy_d[claim_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= IDX_W'(NREQ - 1);
      wen_q    <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        rr_ptr_q <= grant_idx;
        wreg_q   <= sel_reg;
        wdata_q  <= sel_data;
        // The read-only register is accepted but never written.
        wen_q    <= (sel_reg != RO_REG);
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

  assign rf_write_en  = wen_q;
  assign rf_wreg      = wreg_q;
  assign rf_writedata = wdata_q;
  assign busy         = busy_q;

endmodule
